// File: rtl/fp_addsub_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : fp_addsub_pipe                                                  |
// | Desc   : 3-stage floating-point add/sub, RNE, FTZ, flags, valid/ready.   |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
module fp_addsub_pipe #(
    parameter int EXPONENT_WIDTH = 5,
    parameter int MANTISSA_WIDTH = 10
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic                                     in_valid,
    output logic                                     in_ready,
    input  logic                                     op,
    input  logic [EXPONENT_WIDTH+MANTISSA_WIDTH:0]   A_FP,
    input  logic [EXPONENT_WIDTH+MANTISSA_WIDTH:0]   B_FP,
    output logic                                     out_valid,
    input  logic                                     out_ready,
    output logic                                     sign,
    output logic [EXPONENT_WIDTH-1:0]                exponent,
    output logic [MANTISSA_WIDTH-1:0]                mantissa,
    output logic [3:0]                               flags
);
    localparam int E  = EXPONENT_WIDTH;
    localparam int M  = MANTISSA_WIDTH;
    localparam int W  = E + M + 1;
    localparam int SW = M + 4;
    localparam int LW = $clog2(SW + 1);
    localparam int XW = E + LW + 2;
    localparam logic [E-1:0]          C_EXP_ONES  = '1;
    localparam logic [M-1:0]          C_QNAN_FRAC = {1'b1, {(M-1){1'b0}}};
    localparam logic [E-1:0]          C_ALIGN_LIM = E'(M + 3);
    localparam logic signed [XW-1:0]  C_ONE_S     = XW'(1);
    localparam logic signed [XW-1:0]  C_ZERO_S    = XW'(0);
    localparam logic signed [XW-1:0]  C_EXP_OVF   = XW'((1 << E) - 1);

    logic w_en;
    assign w_en     = !(out_valid && !out_ready);
    assign in_ready = w_en;

    // ---------------- Stage 1: unpack, classify, swap ----------------
    logic          w_sa, w_sb, w_sub, w_a_ge;
    logic [E-1:0]  w_ea, w_eb;
    logic [M-1:0]  w_fa, w_fb, w_fa_z, w_fb_z;
    logic          w_zero_a, w_zero_b, w_nan_a, w_nan_b, w_inf_a, w_inf_b;
    logic          w_spec, w_spec_inv;
    logic [W-1:0]  w_spec_res;

    assign {w_sa, w_ea, w_fa} = A_FP;
    assign w_sb     = B_FP[E+M] ^ op;
    assign w_eb     = B_FP[E+M-1:M];
    assign w_fb     = B_FP[M-1:0];
    assign w_sub    = w_sa ^ w_sb;
    assign w_zero_a = (w_ea == '0);
    assign w_zero_b = (w_eb == '0);
    assign w_fa_z   = w_zero_a ? '0 : w_fa;
    assign w_fb_z   = w_zero_b ? '0 : w_fb;
    assign w_nan_a  = (w_ea == C_EXP_ONES) && (w_fa != '0);
    assign w_nan_b  = (w_eb == C_EXP_ONES) && (w_fb != '0);
    assign w_inf_a  = (w_ea == C_EXP_ONES) && (w_fa == '0);
    assign w_inf_b  = (w_eb == C_EXP_ONES) && (w_fb == '0);
    assign w_a_ge   = {w_ea, w_fa_z} >= {w_eb, w_fb_z};

    always_comb begin
        w_spec     = 1'b1;
        w_spec_inv = 1'b0;
        w_spec_res = '0;
        if (w_nan_a || w_nan_b || (w_inf_a && w_inf_b && w_sub)) begin
            w_spec_res = {1'b0, C_EXP_ONES, C_QNAN_FRAC};
            w_spec_inv = 1'b1;
        end else if (w_inf_a) begin
            w_spec_res = {w_sa, C_EXP_ONES, {M{1'b0}}};
        end else if (w_inf_b) begin
            w_spec_res = {w_sb, C_EXP_ONES, {M{1'b0}}};
        end else if (w_zero_a && w_zero_b) begin
            w_spec_res = {w_sa & w_sb, {(E+M){1'b0}}};
        end else begin
            w_spec = 1'b0;
        end
    end

    logic          r1_valid, r1_spec, r1_spec_inv, r1_sign, r1_sub;
    logic [W-1:0]  r1_spec_res;
    logic [E-1:0]  r1_ex, r1_ey;
    logic [M:0]    r1_mx, r1_my;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r1_valid <= 1'b0;  r1_spec <= 1'b0;  r1_spec_inv <= 1'b0;
            r1_sign  <= 1'b0;  r1_sub  <= 1'b0;  r1_spec_res <= '0;
            r1_ex    <= '0;    r1_ey   <= '0;    r1_mx <= '0;  r1_my <= '0;
        end else if (w_en) begin
            r1_valid    <= in_valid;
            r1_spec     <= w_spec;
            r1_spec_inv <= w_spec_inv;
            r1_spec_res <= w_spec_res;
            r1_sub      <= w_sub;
            r1_sign     <= w_a_ge ? w_sa : w_sb;
            r1_ex       <= w_a_ge ? w_ea : w_eb;
            r1_ey       <= w_a_ge ? w_eb : w_ea;
            r1_mx       <= w_a_ge ? {~w_zero_a, w_fa_z} : {~w_zero_b, w_fb_z};
            r1_my       <= w_a_ge ? {~w_zero_b, w_fb_z} : {~w_zero_a, w_fa_z};
        end
    end

    // ---------------- Stage 2: align with G/R/S, add/sub ----------------
    logic [E-1:0]     w_diff;
    logic [2*M+3:0]   w_ysh;
    logic [SW-1:0]    w_xal, w_yal;
    logic [SW:0]      w_sum;

    assign w_diff = r1_ex - r1_ey;
    assign w_ysh  = {r1_my, {(M+3){1'b0}}} >> w_diff;
    assign w_xal  = {r1_mx, 3'b000};
    assign w_yal  = (w_diff >= C_ALIGN_LIM) ? {{(SW-1){1'b0}}, |r1_my}
                                            : {w_ysh[2*M+3:M+1], w_ysh[M] | (|w_ysh[M-1:0])};
    assign w_sum  = r1_sub ? ({1'b0, w_xal} - {1'b0, w_yal}) : ({1'b0, w_xal} + {1'b0, w_yal});

    logic          r2_valid, r2_spec, r2_spec_inv, r2_sign;
    logic [W-1:0]  r2_spec_res;
    logic [E-1:0]  r2_exp;
    logic [SW:0]   r2_sum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r2_valid <= 1'b0;  r2_spec <= 1'b0;  r2_spec_inv <= 1'b0;
            r2_sign  <= 1'b0;  r2_spec_res <= '0;  r2_exp <= '0;  r2_sum <= '0;
        end else if (w_en) begin
            r2_valid    <= r1_valid;
            r2_spec     <= r1_spec;
            r2_spec_inv <= r1_spec_inv;
            r2_spec_res <= r1_spec_res;
            r2_sign     <= r1_sign;
            r2_exp      <= r1_ex;
            r2_sum      <= w_sum;
        end
    end

    // ---------------- Stage 3: normalise, round, pack ----------------
    logic [LW-1:0]           w_lz;
    logic [SW-1:0]           w_norm;
    logic signed [XW-1:0]    w_exp_n, w_exp_r;
    logic [M+1:0]            w_rnd;
    logic [M-1:0]            w_frac;
    logic                    w_rup, w_inexact;
    logic [W-1:0]            w_res;
    logic [3:0]              w_flg;

    always_comb begin
        w_lz = LW'(SW);
        for (int i = 0; i < SW; i++) begin
            if (r2_sum[i]) w_lz = LW'(SW - 1 - i);
        end
        if (r2_sum[SW]) begin
            w_norm  = {r2_sum[SW:2], r2_sum[1] | r2_sum[0]};
            w_exp_n = $signed({{(XW-E){1'b0}}, r2_exp}) + C_ONE_S;
        end else begin
            w_norm  = r2_sum[SW-1:0] << w_lz;
            w_exp_n = $signed({{(XW-E){1'b0}}, r2_exp}) - $signed({{(XW-LW){1'b0}}, w_lz});
        end
        w_inexact = |w_norm[2:0];
        w_rup     = w_norm[2] & (w_norm[1] | w_norm[0] | w_norm[3]);
        w_rnd     = {1'b0, w_norm[SW-1:3]} + {{(M+1){1'b0}}, w_rup};
        // A carry out of rounding leaves an all-zero fraction one binade up
        w_frac    = w_rnd[M+1] ? w_rnd[M:1] : w_rnd[M-1:0];
        w_exp_r   = w_exp_n + (w_rnd[M+1] ? C_ONE_S : C_ZERO_S);

        w_res = {r2_sign, w_exp_r[E-1:0], w_frac};
        w_flg = {3'b000, w_inexact};
        if (r2_spec) begin
            w_res = r2_spec_res;
            w_flg = {r2_spec_inv, 3'b000};
        end else if (r2_sum == '0) begin
            w_res = '0;
            w_flg = 4'b0000;
        end else if (w_exp_r >= C_EXP_OVF) begin
            w_res = {r2_sign, C_EXP_ONES, {M{1'b0}}};
            w_flg = 4'b0101;
        end else if (w_exp_r <= C_ZERO_S) begin
            w_res = {r2_sign, {(E+M){1'b0}}};
            w_flg = 4'b0011;
        end
    end

    logic          r3_valid;
    logic [W-1:0]  r3_res;
    logic [3:0]    r3_flags;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r3_valid <= 1'b0;
            r3_res   <= '0;
            r3_flags <= '0;
        end else if (w_en) begin
            r3_valid <= r2_valid;
            r3_res   <= w_res;
            r3_flags <= w_flg;
        end
    end

    assign out_valid                  = r3_valid;
    assign {sign, exponent, mantissa} = r3_res;
    assign flags                      = r3_flags & {4{r3_valid}};

endmodule
`default_nettype wire

// File: tb/tb_fp_addsub_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : tb_fp_addsub_pipe                                               |
// | Desc   : Scoreboard bench for fp_addsub_pipe (E=5, M=10).                |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
module tb_fp_addsub_pipe;
    localparam int E = 5;
    localparam int M = 10;
    localparam int W = E + M + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          op = 1'b0;
    logic [W-1:0]  A_FP = '0;
    logic [W-1:0]  B_FP = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic          sign;
    logic [E-1:0]  exponent;
    logic [M-1:0]  mantissa;
    logic [3:0]    flags;

    int n_pass  = 0;
    int n_total = 0;
    logic [19:0] sb_q[$];

    // {flags, result} for the stall/reset burst
    logic [15:0] bur_a  [8] = '{16'h4740, 16'h5410, 16'h3C00, 16'h4000, 16'h3C00, 16'h4200, 16'h3C00, 16'h7C01};
    logic        bur_op [8] = '{1'b0,     1'b1,     1'b0,     1'b0,     1'b1,     1'b0,     1'b0,     1'b0};
    logic [15:0] bur_b  [8] = '{16'h3600, 16'h53E0, 16'h3C00, 16'h4000, 16'h4000, 16'h3C00, 16'hFC00, 16'h3C00};
    logic [19:0] bur_e  [8] = '{20'h047A0, 20'h04000, 20'h04000, 20'h04400, 20'h0BC00, 20'h04400, 20'h0FC00, 20'h87E00};

    always #5 clk = ~clk;

    fp_addsub_pipe #(.EXPONENT_WIDTH(E), .MANTISSA_WIDTH(M)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .A_FP(A_FP), .B_FP(B_FP), .out_valid(out_valid), .out_ready(out_ready),
        .sign(sign), .exponent(exponent), .mantissa(mantissa), .flags(flags)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    endtask

    // Output side of the scoreboard: every accepted result must match the oldest expectation
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            n_total++;
            assert (sb_q.size() != 0) n_pass++;
            else $error("FAIL unexpected_output: observed %h%h expected no output", flags, {sign, exponent, mantissa});
            if (sb_q.size() != 0) chk("result", {12'h0, flags, sign, exponent, mantissa}, {12'h0, sb_q.pop_front()});
        end
    end

    task automatic send(input logic [15:0] a, input logic o, input logic [15:0] b, input logic [19:0] expv);
        int t;
        A_FP = a; B_FP = b; op = o; in_valid = 1'b1;
        t = 0;
        @(negedge clk);
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("send_in_ready", in_ready, 1);
        sb_q.push_back(expv);
        @(posedge clk); #1;
    endtask

    task automatic drain();
        int t;
        in_valid = 1'b0;
        t = 0;
        while (sb_q.size() != 0 && t < 60) begin
            @(posedge clk);
            t++;
        end
        #1;
        chk("drain_empty", sb_q.size(), 0);
    endtask

    initial begin
        #3;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_result", {sign, exponent, mantissa}, 0);
        chk("rst_flags", flags, 0);
        chk("rst_in_ready", in_ready, 1);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // Latency: accepted result appears after exactly three edges
        send(16'h4740, 1'b0, 16'h3600, 20'h047A0);
        in_valid = 1'b0;
        chk("lat_s1", out_valid, 0);
        @(posedge clk); #1;
        chk("lat_s2", out_valid, 0);
        @(posedge clk); #1;
        chk("lat_s3", out_valid, 1);
        drain();

        // Directed arithmetic and corner cases, streamed back-to-back
        send(16'h5410, 1'b0, 16'hD3E0, 20'h04000);
        send(16'h5410, 1'b1, 16'h53E0, 20'h04000);
        send(16'h4400, 1'b1, 16'h4400, 20'h00000);
        send(16'h8000, 1'b0, 16'h8000, 20'h08000);
        send(16'h3C01, 1'b0, 16'h1000, 20'h13C02);
        send(16'h3C00, 1'b0, 16'h1000, 20'h13C00);
        send(16'h7BFF, 1'b0, 16'h7BFF, 20'h57C00);
        send(16'h7C00, 1'b1, 16'h7C00, 20'h87E00);
        send(16'h0401, 1'b1, 16'h0400, 20'h30000);
        send(16'h3C00, 1'b0, 16'h0001, 20'h03C00);
        send(16'h7E00, 1'b0, 16'h3C00, 20'h87E00);
        drain();

        // Burst with a 4-cycle downstream stall in the middle
        for (int i = 0; i < 4; i++) send(bur_a[i], bur_op[i], bur_b[i], bur_e[i]);
        out_ready = 1'b0;
        A_FP = bur_a[4]; B_FP = bur_b[4]; op = bur_op[4]; in_valid = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("stall_in_ready", in_ready, 0);
            chk("stall_hold", {11'h0, out_valid, flags, sign, exponent, mantissa}, {11'h0, 1'b1, bur_e[1]});
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        for (int i = 4; i < 8; i++) send(bur_a[i], bur_op[i], bur_b[i], bur_e[i]);
        drain();

        // Asynchronous reset mid-burst discards everything in flight
        for (int i = 0; i < 4; i++) send(bur_a[i], bur_op[i], bur_b[i], bur_e[i]);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_flags", flags, 0);
        sb_q.delete();
        @(negedge clk) rst_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        chk("post_rst_quiet", out_valid, 0);
        send(16'h4200, 1'b0, 16'h3C00, 20'h04400);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
